rr_bus_arbiter: RTL and testbench
=================================

RR_BUS_ARBITER -- requirements
Module: rr_bus_arbiter

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 Parameter DATA_WIDTH, default 1: width of every data port.
REQ-003 Parameter CNT_WIDTH, default 16: width of beat_count.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 IN_DATA_A  input  DATA_WIDTH  requester A data.
REQ-007 in_valid_a  input  1  requester A beat valid.
REQ-008 in_last_a  input  1  requester A final beat of packet.
REQ-009 IN_READY_A  output  1  requester A beat accepted this cycle when high with in_valid_a.
REQ-010 in_data_b, IN_VALID_B, IN_LAST_B, in_ready_b SHALL mirror REQ-006..REQ-009 for requester B, with identical directions and widths.
REQ-011 out_data  output  DATA_WIDTH  registered shared-stage data.
REQ-012 OUT_VALID  output  1  out_data holds a beat.
REQ-013 OUT_LAST  output  1  beat is the final beat of its packet.
REQ-014 out_src  output  1  source of the held beat: 0 = A, 1 = B.
REQ-015 out_ready  input  1  downstream accepts the held beat.
REQ-016 beat_count  output  CNT_WIDTH  delivered-beat counter.

Function
REQ-017 Output stage SHALL be a single registered entry; "space" = !OUT_VALID | out_ready.
- The out_ready-to-ready combinational path is permitted.
REQ-018 FSM states:
- IDLE: no packet in progress.
- LOCKED: a packet is in progress from the granted requester.
REQ-019 In IDLE with exactly one requester valid, that requester SHALL be granted in the same cycle.
REQ-020 In IDLE with both requesters valid, the requester selected by the 1-bit priority pointer SHALL be granted.
REQ-021 Only the granted requester's ready SHALL be asserted, and only when there is space; the other ready SHALL be 0.
REQ-022 An accepted beat (valid & ready) SHALL appear on out_data/OUT_LAST/out_src with OUT_VALID=1 on the next cycle (latency 1).
REQ-023 With OUT_VALID=1 and out_ready=0, the output entry SHALL hold all its fields unchanged.
REQ-024 If the first accepted beat has last=0, the FSM SHALL go IDLE->LOCKED and hold the grant.
- No other requester is served until that packet completes.
REQ-025 In LOCKED, an accepted beat with last=1 SHALL return the FSM to IDLE and set the pointer to the other requester.
REQ-026 A single-beat packet (last=1 on the first beat) SHALL stay in IDLE and toggle the pointer.
REQ-027 A granted requester dropping valid mid-packet SHALL keep LOCKED (bubble), with no re-arbitration.
REQ-028 Draining the held beat and accepting a new beat in the same cycle SHALL sustain 1 beat/cycle.
REQ-029 beat_count SHALL increment on each OUT_VALID & out_ready and saturate at all-ones (no wrap).
REQ-030 An IDLE cycle with no space SHALL grant nothing and leave the pointer unchanged.

Reset
REQ-031 rst SHALL asynchronously force:
- OUT_VALID, OUT_LAST, out_src, out_data, beat_count to 0;
- FSM to IDLE;
- pointer to A.
REQ-032 While rst is high, IN_READY_A and in_ready_b SHALL be 0.
REQ-033 rst asserted mid-packet SHALL discard the held beat and the lock; after release the next arbitration starts fresh from pointer=A.

Structure
REQ-034 A shared package SHALL hold the FSM state enum (IDLE, LOCKED) and the source encoding constants SRC_A=0, SRC_B=1.
REQ-035 The output register stage SHALL be one sub-module, rr_out_stage (data/last/src register with valid/ready hold).
- Arbitration FSM, pointer and counter live in the top.

Verification
REQ-036 A sends 3 beats 1,0,1 (last on the third) while B is held valid, out_ready=1 -> out_src=0 for 3 consecutive cycles, then B granted; in_ready_b=0 throughout A's packet.
REQ-037 Both valid from reset with single-beat packets, out_ready=1 -> out_src sequence 0,1,0,1; beat_count=4 after the 4th delivery.
REQ-038 A beat accepted, then out_ready=0 for 3 cycles -> OUT_VALID, out_data, out_src stable; IN_READY_A=0; delivery happens on the cycle out_ready rises.
REQ-039 CNT_WIDTH=2, deliver 5 beats -> beat_count 1,2,3,3,3.
REQ-040 rst pulsed while LOCKED on B with a beat held -> OUT_VALID=0 and beat_count=0 immediately; with both valid after release, A granted first.
REQ-041 B drops valid for 2 cycles mid-packet while A is valid -> no beats from A until B's last beat is accepted.

Source files
------------

// File: rtl/rr_bus_arbiter_pkg.sv
// Shared types and constants for the two-requester round-robin bus arbiter.
package rr_bus_arbiter_pkg;

    typedef enum logic {
        IDLE,
        LOCKED
    } arb_state_t;

    localparam logic SRC_A = 1'b0;
    localparam logic SRC_B = 1'b1;

endpackage

// File: rtl/rr_out_stage.sv
// Single-entry registered output stage: loads a beat, holds it under backpressure,
// and empties when the held beat is taken without a replacement.
module rr_out_stage #(
    parameter int DATA_WIDTH = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic                  load_last,
    input  logic                  load_src,
    input  logic                  out_ready,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    output logic                  out_src,
    output logic                  space
);

    assign space = !out_valid || out_ready;

    // Fields change only on load so a stalled beat stays bit-stable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            out_src   <= 1'b0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_data  <= load_data;
            out_last  <= load_last;
            out_src   <= load_src;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/rr_bus_arbiter.sv
// Two-requester packet arbiter: round-robin between packets, grant locked for the
// duration of a multi-beat packet, one registered output entry, saturating beat counter.
module rr_bus_arbiter
    import rr_bus_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH = 1,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] IN_DATA_A,
    input  logic                  in_valid_a,
    input  logic                  in_last_a,
    output logic                  IN_READY_A,
    input  logic [DATA_WIDTH-1:0] in_data_b,
    input  logic                  IN_VALID_B,
    input  logic                  IN_LAST_B,
    output logic                  in_ready_b,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  OUT_VALID,
    output logic                  OUT_LAST,
    output logic                  out_src,
    input  logic                  out_ready,
    output logic [CNT_WIDTH-1:0]  beat_count
);

    arb_state_t            state;
    logic                  ptr;
    logic                  owner;
    logic                  space;
    logic                  grant_valid;
    logic                  grant_src;
    logic                  sel_valid;
    logic                  sel_last;
    logic [DATA_WIDTH-1:0] sel_data;
    logic                  accept;

    // While locked the owner keeps the grant even if it bubbles.
    always_comb begin
        grant_valid = 1'b0;
        grant_src   = SRC_A;
        if (state == LOCKED) begin
            grant_valid = 1'b1;
            grant_src   = owner;
        end else if (in_valid_a && IN_VALID_B) begin
            grant_valid = 1'b1;
            grant_src   = ptr;
        end else if (in_valid_a) begin
            grant_valid = 1'b1;
            grant_src   = SRC_A;
        end else if (IN_VALID_B) begin
            grant_valid = 1'b1;
            grant_src   = SRC_B;
        end
    end

    assign sel_valid  = (grant_src == SRC_B) ? IN_VALID_B : in_valid_a;
    assign sel_last   = (grant_src == SRC_B) ? IN_LAST_B  : in_last_a;
    assign sel_data   = (grant_src == SRC_B) ? in_data_b  : IN_DATA_A;

    assign IN_READY_A = !rst && space && grant_valid && (grant_src == SRC_A);
    assign in_ready_b = !rst && space && grant_valid && (grant_src == SRC_B);
    assign accept     = sel_valid && !rst && space && grant_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            ptr   <= SRC_A;
            owner <= SRC_A;
        end else if (accept) begin
            if (sel_last) begin
                state <= IDLE;
                ptr   <= ~grant_src;
            end else begin
                state <= LOCKED;
                owner <= grant_src;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat_count <= '0;
        end else if (OUT_VALID && out_ready && (beat_count != '1)) begin
            beat_count <= beat_count + 1'b1;
        end
    end

    rr_out_stage #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_out_stage (
        .clk      (clk),
        .rst      (rst),
        .load     (accept),
        .load_data(sel_data),
        .load_last(sel_last),
        .load_src (grant_src),
        .out_ready(out_ready),
        .out_valid(OUT_VALID),
        .out_data (out_data),
        .out_last (OUT_LAST),
        .out_src  (out_src),
        .space    (space)
    );

endmodule

// File: tb/tb_rr_bus_arbiter.sv
// Randomized and directed bench for rr_bus_arbiter against a packet-level ownership model.
module tb_rr_bus_arbiter;

    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] da = '0, db = '0;
    logic          va = 1'b0, la = 1'b0, vb = 1'b0, lb = 1'b0, ordy = 1'b0;

    logic          ra, rb, ov, ol, os;
    logic [DW-1:0] od;
    logic [15:0]   bc;
    logic          ra2, rb2, ov2, ol2, os2;
    logic [DW-1:0] od2;
    logic [1:0]    bc2;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    rr_bus_arbiter #(.DATA_WIDTH(DW), .CNT_WIDTH(16)) dut (
        .clk(clk), .rst(rst),
        .IN_DATA_A(da), .in_valid_a(va), .in_last_a(la), .IN_READY_A(ra),
        .in_data_b(db), .IN_VALID_B(vb), .IN_LAST_B(lb), .in_ready_b(rb),
        .out_data(od), .OUT_VALID(ov), .OUT_LAST(ol), .out_src(os),
        .out_ready(ordy), .beat_count(bc)
    );

    rr_bus_arbiter #(.DATA_WIDTH(DW), .CNT_WIDTH(2)) dut_sat (
        .clk(clk), .rst(rst),
        .IN_DATA_A(da), .in_valid_a(va), .in_last_a(la), .IN_READY_A(ra2),
        .in_data_b(db), .IN_VALID_B(vb), .IN_LAST_B(lb), .in_ready_b(rb2),
        .out_data(od2), .OUT_VALID(ov2), .OUT_LAST(ol2), .out_src(os2),
        .out_ready(ordy), .beat_count(bc2)
    );

    // Model: who owns the bus (-1 = nobody), whose turn is next, the held beat, deliveries.
    int            m_owner;
    bit            m_ptr;
    bit            m_hv, m_hl, m_hs;
    logic [DW-1:0] m_hd;
    int unsigned   m_deliv;
    bit            e_ra, e_rb;

    task automatic model_clear();
        m_owner = -1; m_ptr = 0; m_hv = 0; m_hl = 0; m_hs = 0; m_hd = '0; m_deliv = 0;
    endtask

    task automatic predict();
        bit space;
        int g;
        space = !m_hv || ordy;
        if (m_owner >= 0)   g = m_owner;
        else if (va && vb)  g = int'(m_ptr);
        else if (va)        g = 0;
        else if (vb)        g = 1;
        else                g = -1;
        e_ra = !rst && space && (g == 0);
        e_rb = !rst && space && (g == 1);
    endtask

    task automatic model_edge();
        bit            acc, src, l;
        logic [DW-1:0] d;
        if (m_hv && ordy) m_deliv++;
        acc = (va && e_ra) || (vb && e_rb);
        src = e_rb;
        d   = src ? db : da;
        l   = src ? lb : la;
        if (acc) begin
            m_hv = 1; m_hd = d; m_hl = l; m_hs = src;
            if (l) begin m_owner = -1; m_ptr = !src; end
            else   m_owner = int'(src);
        end else if (ordy) begin
            m_hv = 0;
        end
    endtask

    function automatic int unsigned sat(input int unsigned v, input int unsigned mx);
        return (v > mx) ? mx : v;
    endfunction

    task automatic settle();
        #1;
        predict();
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1; va = 0; vb = 0; la = 0; lb = 0; ordy = 0; da = '0; db = '0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_clear();
    endtask

    task automatic test_reset();
        rst = 1'b1; va = 1; vb = 1; la = 0; lb = 0; ordy = 1;
        settle();
        n_checks++; if (ra !== 1'b0 || rb !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got a=%b b=%b expected 0 0", ra, rb); end
        n_checks++; if (ov !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", ov); end
        n_checks++; if (bc !== 16'd0 || bc2 !== 2'd0) begin n_fail++; $display("FAIL reset_count: got %0d/%0d expected 0/0", bc, bc2); end
        n_checks++; if (od !== '0 || ol !== 1'b0 || os !== 1'b0) begin n_fail++; $display("FAIL reset_fields: got data=%0h last=%b src=%b expected 0", od, ol, os); end
        @(negedge clk);
        do_reset();
    endtask

    task automatic test_locked_packet();
        logic [DW-1:0] beats [3];
        beats[0] = 8'd1; beats[1] = 8'd0; beats[2] = 8'd1;
        do_reset();
        ordy = 1; vb = 1; lb = 1; db = 8'hB0; va = 1;
        for (int k = 0; k < 5; k++) begin
            if (k < 3) begin da = beats[k]; la = (k == 2); end
            else begin da = 8'h77; la = 1; end
            settle();
            if (k < 3) begin
                n_checks++; if (rb !== 1'b0 || ra !== 1'b1) begin n_fail++; $display("FAIL lock_ready k=%0d: got a=%b b=%b expected 1 0", k, ra, rb); end
            end
            if (k == 3) begin
                n_checks++; if (rb !== 1'b1 || ra !== 1'b0) begin n_fail++; $display("FAIL lock_handover: got a=%b b=%b expected 0 1", ra, rb); end
            end
            if (k >= 1 && k <= 3) begin
                n_checks++; if (ov !== 1'b1 || os !== 1'b0 || od !== beats[k-1]) begin n_fail++; $display("FAIL lock_out k=%0d: got v=%b src=%b data=%0h expected 1 0 %0h", k, ov, os, od, beats[k-1]); end
            end
            if (k == 4) begin
                n_checks++; if (ov !== 1'b1 || os !== 1'b1 || od !== 8'hB0) begin n_fail++; $display("FAIL lock_then_b: got v=%b src=%b data=%0h expected 1 1 b0", ov, os, od); end
            end
            tick();
        end
    endtask

    task automatic test_alternate();
        bit exp_seq [4];
        exp_seq[0] = 0; exp_seq[1] = 1; exp_seq[2] = 0; exp_seq[3] = 1;
        do_reset();
        ordy = 1; va = 1; vb = 1; la = 1; lb = 1;
        for (int k = 0; k < 6; k++) begin
            da = 8'(8'h10 + k); db = 8'(8'h20 + k);
            if (k >= 4) begin va = 0; vb = 0; end
            settle();
            if (k >= 1 && k <= 4) begin
                n_checks++; if (ov !== 1'b1 || os !== exp_seq[k-1]) begin n_fail++; $display("FAIL alt_src k=%0d: got v=%b src=%b expected 1 %b", k, ov, os, exp_seq[k-1]); end
            end
            if (k == 5) begin
                n_checks++; if (bc !== 16'd4) begin n_fail++; $display("FAIL alt_count: got %0d expected 4", bc); end
            end
            tick();
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        ordy = 1; va = 1; la = 1; da = 8'h5A;
        settle();
        n_checks++; if (ra !== 1'b1) begin n_fail++; $display("FAIL bp_first_ready: got %b expected 1", ra); end
        tick();
        da = 8'hC3; ordy = 0;
        for (int k = 0; k < 3; k++) begin
            settle();
            n_checks++; if (ov !== 1'b1 || od !== 8'h5A || os !== 1'b0 || ol !== 1'b1) begin n_fail++; $display("FAIL bp_hold k=%0d: got v=%b data=%0h src=%b last=%b expected 1 5a 0 1", k, ov, od, os, ol); end
            n_checks++; if (ra !== 1'b0) begin n_fail++; $display("FAIL bp_ready k=%0d: got %b expected 0", k, ra); end
            n_checks++; if (bc !== 16'd0) begin n_fail++; $display("FAIL bp_count k=%0d: got %0d expected 0", k, bc); end
            tick();
        end
        ordy = 1;
        settle();
        n_checks++; if (ra !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready: got %b expected 1", ra); end
        tick();
        va = 0;
        settle();
        n_checks++; if (bc !== 16'd1 || od !== 8'hC3 || ov !== 1'b1) begin n_fail++; $display("FAIL bp_deliver: got count=%0d data=%0h v=%b expected 1 c3 1", bc, od, ov); end
        tick();
    endtask

    task automatic test_saturation();
        int unsigned exp_c [5];
        exp_c[0] = 1; exp_c[1] = 2; exp_c[2] = 3; exp_c[3] = 3; exp_c[4] = 3;
        do_reset();
        ordy = 1; va = 1; la = 1;
        for (int k = 0; k < 7; k++) begin
            da = 8'(k);
            settle();
            if (k >= 2) begin
                n_checks++; if (bc2 !== 2'(exp_c[k-2])) begin n_fail++; $display("FAIL sat_count k=%0d: got %0d expected %0d", k, bc2, exp_c[k-2]); end
                n_checks++; if (bc !== 16'(k - 1)) begin n_fail++; $display("FAIL wide_count k=%0d: got %0d expected %0d", k, bc, k - 1); end
            end
            tick();
        end
        va = 0;
    endtask

    task automatic test_reset_mid_packet();
        do_reset();
        ordy = 1; vb = 1; lb = 0; db = 8'h31;
        settle(); tick();
        db = 8'h32;
        settle(); tick();
        ordy = 0; va = 1; la = 1; da = 8'h41;
        settle();
        n_checks++; if (ra !== 1'b0 || ov !== 1'b1 || os !== 1'b1 || bc !== 16'd1) begin n_fail++; $display("FAIL mid_pre: got a=%b v=%b src=%b count=%0d expected 0 1 1 1", ra, ov, os, bc); end
        #1 rst = 1'b1;
        #1;
        n_checks++; if (ov !== 1'b0 || bc !== 16'd0) begin n_fail++; $display("FAIL mid_reset: got v=%b count=%0d expected 0 0", ov, bc); end
        n_checks++; if (ra !== 1'b0 || rb !== 1'b0) begin n_fail++; $display("FAIL mid_reset_ready: got a=%b b=%b expected 0 0", ra, rb); end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0; model_clear();
        ordy = 1; lb = 1;
        settle();
        n_checks++; if (ra !== 1'b1 || rb !== 1'b0) begin n_fail++; $display("FAIL mid_fresh: got a=%b b=%b expected 1 0", ra, rb); end
        tick();
        va = 0; vb = 0;
        settle();
        n_checks++; if (ov !== 1'b1 || os !== 1'b0 || od !== 8'h41) begin n_fail++; $display("FAIL mid_fresh_out: got v=%b src=%b data=%0h expected 1 0 41", ov, os, od); end
        tick();
    endtask

    task automatic test_bubble();
        do_reset();
        ordy = 1; vb = 1; lb = 0; db = 8'h60;
        settle(); tick();
        vb = 0; va = 1; la = 1; da = 8'hA0;
        for (int k = 0; k < 2; k++) begin
            settle();
            n_checks++; if (ra !== 1'b0 || rb !== 1'b1) begin n_fail++; $display("FAIL bubble_ready k=%0d: got a=%b b=%b expected 0 1", k, ra, rb); end
            tick();
        end
        vb = 1; lb = 1; db = 8'h61;
        settle();
        n_checks++; if (ra !== 1'b0 || rb !== 1'b1 || ov !== 1'b0) begin n_fail++; $display("FAIL bubble_last: got a=%b b=%b v=%b expected 0 1 0", ra, rb, ov); end
        tick();
        vb = 0;
        settle();
        n_checks++; if (ra !== 1'b1 || ov !== 1'b1 || os !== 1'b1 || od !== 8'h61) begin n_fail++; $display("FAIL bubble_after: got a=%b v=%b src=%b data=%0h expected 1 1 1 61", ra, ov, os, od); end
        tick();
        va = 0;
    endtask

    task automatic test_random();
        do_reset();
        for (int k = 0; k < 400; k++) begin
            va   = ($urandom_range(0, 3) != 0);
            vb   = ($urandom_range(0, 3) != 0);
            la   = ($urandom_range(0, 2) == 0);
            lb   = ($urandom_range(0, 2) == 0);
            da   = 8'($urandom);
            db   = 8'($urandom);
            ordy = ($urandom_range(0, 3) != 0);
            settle();
            n_checks++; if (ra !== e_ra || rb !== e_rb) begin n_fail++; $display("FAIL rnd_ready k=%0d: got a=%b b=%b expected %b %b", k, ra, rb, e_ra, e_rb); end
            n_checks++; if (ov !== m_hv) begin n_fail++; $display("FAIL rnd_valid k=%0d: got %b expected %b", k, ov, m_hv); end
            if (m_hv) begin
                n_checks++; if (od !== m_hd || ol !== m_hl || os !== m_hs) begin n_fail++; $display("FAIL rnd_beat k=%0d: got data=%0h last=%b src=%b expected %0h %b %b", k, od, ol, os, m_hd, m_hl, m_hs); end
            end
            n_checks++; if (bc !== 16'(sat(m_deliv, 65535)) || bc2 !== 2'(sat(m_deliv, 3))) begin n_fail++; $display("FAIL rnd_count k=%0d: got %0d/%0d expected %0d/%0d", k, bc, bc2, sat(m_deliv, 65535), sat(m_deliv, 3)); end
            tick();
        end
    endtask

    initial begin
        model_clear();
        @(negedge clk);
        test_reset();
        test_locked_packet();
        test_alternate();
        test_backpressure();
        test_saturation();
        test_reset_mid_packet();
        test_bubble();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
